icache_arb: RTL and testbench
=============================

ICACHE_ARB -- requirements
Module: icache_arb

Interface
REQ-001 Parameter MAX_OUTST, default 4: number of request IDs in the pool (2..8); pool IDs are 0..MAX_OUTST-1.
REQ-002 Parameter PF_STARVE, default 8: consecutive denied prefetch cycles that trigger one forced prefetch grant.
REQ-003 clk  in  1  sole clock; all flops are posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 dmd_req_nnn  in  t_mem_req  demand fetch request (valid, id, addr).
REQ-006 dmd_gnt_nnn  out  1  demand request accepted this cycle.
REQ-007 pf_req_nnn  in  t_mem_req  prefetch request (valid, id, addr).
REQ-008 pf_gnt_nnn  out  1  prefetch request accepted this cycle.
REQ-009 fb_ic_req_nnn  out  t_mem_req  request to icache; id is the pool ID.
REQ-010 ic_fb_rsp_nnn  in  t_mem_rsp  icache response (valid, id, data), fixed latency, no backpressure.
REQ-011 dmd_rsp_nnn  out  t_mem_rsp  routed demand response; id is the requester's original id.
REQ-012 pf_rsp_nnn  out  t_mem_rsp  routed prefetch response; id is the requester's original id.
REQ-013 flush  in  1  squash all in-flight requests.
REQ-014 busy  out  1  one or more pool entries valid.
REQ-015 err_sticky  out  1  sticky flag for a response whose pool entry is not valid.

Function
REQ-016 Each pool entry holds: valid, src (dmd/pf), orig_id, squash.
REQ-017 A grant requires a free entry; the allocated entry is the lowest-index free entry.
REQ-018 Priority is demand over prefetch, except that when starve_cnt==PF_STARVE, prefetch wins that cycle.
REQ-019 At most one grant per cycle; the grant is combinational from current state and the request valids.
REQ-020 starve_cnt increments (saturating) on each cycle with pf valid, a free entry and no pf grant; it clears on pf grant or when pf valid is low.
REQ-021 The granted request appears on fb_ic_req_nnn exactly 1 cycle after the grant, with addr passed unchanged and id equal to the pool ID; fb_ic_req_nnn.valid is 0 otherwise.
REQ-022 On the grant cycle the entry is set valid with src/orig_id captured and squash=0.
REQ-023 On ic_fb_rsp_nnn.valid, the entry indexed by id is looked up combinationally; if it is valid and not squashed, the response is driven on the src response port in the same cycle, data passes through, and id is replaced by orig_id.
REQ-024 The non-selected response port has valid=0 at all times.
REQ-025 The responding entry is cleared at the clock edge and is allocatable no earlier than the next cycle; there is no same-cycle reuse.
REQ-026 A response to a squashed entry is dropped (both response valids 0) and the entry is freed.
REQ-027 A response to an invalid entry is dropped and err_sticky is set; err_sticky clears only on reset.
REQ-028 When flush=1: no grant that cycle, and every entry valid at that edge gets squash=1.
REQ-029 A response arriving in the flush cycle uses the pre-flush state and is delivered.
REQ-030 A request granted in the cycle before flush is still issued to the icache, but its entry is squashed.
REQ-031 Pool full (all valid): both grants 0 and starve_cnt holds.
REQ-032 busy = OR of entry valids; it is registered-state based with no combinational path from the inputs.

Reset
REQ-033 On reset assertion, asynchronously: all entries invalid; fb_ic_req_nnn.valid=0; starve_cnt=0; err_sticky=0.
REQ-034 During reset, dmd_gnt_nnn, pf_gnt_nnn, dmd_rsp_nnn.valid and pf_rsp_nnn.valid are forced to 0.
REQ-035 Icache responses arriving during or after reset for pre-reset IDs are treated as invalid-entry responses only when they arrive after reset deasserts.

Verification
REQ-036 Both requesters valid every cycle, MAX_OUTST=4, icache LATENCY=1 -> demand is granted continuously and prefetch wins on the cycle after 8 denials.
REQ-037 Five demand requests with ids 10..14 and the icache stalled (no responses) -> four grants using pool IDs 0,1,2,3, fifth gnt=0, busy=1.
REQ-038 Pool ID 2 response while entry 2 holds a prefetch with orig_id 7 -> pf_rsp_nnn.valid=1, id=7, data matches; dmd_rsp_nnn.valid=0; entry 2 is re-granted no earlier than the next cycle.
REQ-039 Flush with entries 0 and 1 outstanding -> their later responses are dropped, busy falls to 0 after the second response, and no grant occurs in the flush cycle.
REQ-040 Response with id 3 while entry 3 is invalid -> no response valid, err_sticky=1 until reset.
REQ-041 Reset asserted with three entries outstanding -> all outputs 0 immediately; after release, the first request is granted pool ID 0.

Source files
------------

// File: rtl/icache_arb.sv
// icache_arb: demand/prefetch arbiter that remaps requester ids onto a pool of icache request ids
package icache_arb_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } t_mem_req;
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } t_mem_rsp;
endpackage

module icache_arb
  import icache_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int PF_STARVE = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  t_mem_req dmd_req_nnn,
  output logic     dmd_gnt_nnn,
  input  t_mem_req pf_req_nnn,
  output logic     pf_gnt_nnn,
  output t_mem_req fb_ic_req_nnn,
  input  t_mem_rsp ic_fb_rsp_nnn,
  output t_mem_rsp dmd_rsp_nnn,
  output t_mem_rsp pf_rsp_nnn,
  input  logic     flush,
  output logic     busy,
  output logic     err_sticky
);
  localparam int IW = $clog2(MAX_OUTST);
  localparam int NE = 1 << IW;
  localparam int SW = $clog2(PF_STARVE + 1);
  // Storage is rounded up to a power of two so any truncated response id indexes safely.
  logic [NE-1:0]   ent_v, ent_pf, ent_sq;
  logic [ID_W-1:0] ent_oid [NE];
  logic [SW-1:0]   starve_cnt;
  logic [IW-1:0]   alloc, rsp_idx;
  logic            any_free, pf_force, gnt, rsp_hit, rsp_ok;
  always_comb begin
    alloc = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) alloc = ent_v[i] ? alloc : IW'(i);
  end
  assign any_free    = ~&ent_v[MAX_OUTST-1:0];
  assign pf_force    = starve_cnt == SW'(PF_STARVE);
  assign pf_gnt_nnn  = !reset && !flush && any_free && pf_req_nnn.valid && (pf_force || !dmd_req_nnn.valid);
  assign dmd_gnt_nnn = !reset && !flush && any_free && dmd_req_nnn.valid && !pf_gnt_nnn;
  assign gnt         = dmd_gnt_nnn || pf_gnt_nnn;
  assign rsp_idx     = ic_fb_rsp_nnn.id[IW-1:0];
  assign rsp_hit     = ic_fb_rsp_nnn.valid && (ic_fb_rsp_nnn.id < ID_W'(MAX_OUTST)) && ent_v[rsp_idx];
  assign rsp_ok      = rsp_hit && !ent_sq[rsp_idx] && !reset;
  assign busy        = |ent_v;
  always_comb begin
    dmd_rsp_nnn.valid = rsp_ok && !ent_pf[rsp_idx];
    dmd_rsp_nnn.id    = ent_oid[rsp_idx];
    dmd_rsp_nnn.data  = ic_fb_rsp_nnn.data;
    pf_rsp_nnn.valid  = rsp_ok && ent_pf[rsp_idx];
    pf_rsp_nnn.id     = ent_oid[rsp_idx];
    pf_rsp_nnn.data   = ic_fb_rsp_nnn.data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_v         <= '0;
      ent_pf        <= '0;
      ent_sq        <= '0;
      for (int i = 0; i < NE; i++) ent_oid[i] <= '0;
      starve_cnt    <= '0;
      fb_ic_req_nnn <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (flush) ent_sq <= ent_sq | ent_v;
      if (rsp_hit) ent_v[rsp_idx] <= 1'b0;
      if (ic_fb_rsp_nnn.valid && !rsp_hit) err_sticky <= 1'b1;
      if (gnt) begin
        ent_v[alloc]   <= 1'b1;
        ent_pf[alloc]  <= pf_gnt_nnn;
        ent_sq[alloc]  <= 1'b0;
        ent_oid[alloc] <= pf_gnt_nnn ? pf_req_nnn.id : dmd_req_nnn.id;
      end
      fb_ic_req_nnn <= '{valid: gnt, id: ID_W'(alloc), addr: pf_gnt_nnn ? pf_req_nnn.addr : dmd_req_nnn.addr};
      starve_cnt    <= (!pf_req_nnn.valid || pf_gnt_nnn) ? '0 :
                       (any_free && !pf_force) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_icache_arb.sv
// tb_icache_arb: directed scenarios plus randomized lockstep comparison against a pool-level model
module tb_icache_arb;
  import icache_arb_pkg::*;
  localparam int N = 4;
  localparam int PS = 8;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  t_mem_req dmd_req, pf_req, fb_req;
  t_mem_rsp ic_rsp, dmd_rsp, pf_rsp;
  logic dmd_gnt, pf_gnt, busy, err_sticky;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  icache_arb #(.MAX_OUTST(N), .PF_STARVE(PS)) dut (
    .clk(clk), .reset(reset), .dmd_req_nnn(dmd_req), .dmd_gnt_nnn(dmd_gnt),
    .pf_req_nnn(pf_req), .pf_gnt_nnn(pf_gnt), .fb_ic_req_nnn(fb_req), .ic_fb_rsp_nnn(ic_rsp),
    .dmd_rsp_nnn(dmd_rsp), .pf_rsp_nnn(pf_rsp), .flush(flush), .busy(busy), .err_sticky(err_sticky)
  );
  typedef struct { bit v; bit pf; bit sq; logic [3:0] oid; } ent_t;
  ent_t pool [N];
  int starve, e_free, m_fbid;
  bit m_err, m_fbv, e_dg, e_pg, e_dv, e_pv, e_hit;
  logic [3:0] e_rid;
  logic [31:0] m_fbaddr;
  task automatic set_req(input bit dv, input int did, input bit pv, input int pid);
    dmd_req = '{valid: dv, id: 4'(did), addr: $urandom};
    pf_req  = '{valid: pv, id: 4'(pid), addr: $urandom};
  endtask
  task automatic set_rsp(input bit v, input int id, input logic [31:0] d);
    ic_rsp = '{valid: v, id: 4'(id), data: d};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    foreach (pool[i]) pool[i] = '{v: 0, pf: 0, sq: 0, oid: 4'd0};
    starve = 0;
    m_err = 0;
    m_fbv = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    set_req(0, 0, 0, 0);
    set_rsp(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask
  task automatic model_eval();
    int r;
    e_free = -1;
    for (int i = N - 1; i >= 0; i--) if (!pool[i].v) e_free = i;
    e_pg = !flush && e_free >= 0 && pf_req.valid && (starve == PS || !dmd_req.valid);
    e_dg = !flush && e_free >= 0 && dmd_req.valid && !e_pg;
    r = int'(ic_rsp.id);
    e_hit = 0; e_dv = 0; e_pv = 0; e_rid = 4'd0;
    if (ic_rsp.valid && r < N) begin
      e_hit = pool[r].v;
      e_dv = e_hit && !pool[r].sq && !pool[r].pf;
      e_pv = e_hit && !pool[r].sq && pool[r].pf;
      e_rid = pool[r].oid;
    end
  endtask
  task automatic model_commit();
    if (ic_rsp.valid) begin
      if (e_hit) pool[int'(ic_rsp.id)].v = 0;
      else m_err = 1;
    end
    if (flush) foreach (pool[i]) if (pool[i].v) pool[i].sq = 1;
    m_fbv = e_dg || e_pg;
    if (m_fbv) begin
      m_fbid = e_free;
      m_fbaddr = e_pg ? pf_req.addr : dmd_req.addr;
      pool[e_free] = '{v: 1, pf: e_pg, sq: 0, oid: e_pg ? pf_req.id : dmd_req.id};
    end
    if (!pf_req.valid || e_pg) starve = 0;
    else if (e_free >= 0 && starve < PS) starve++;
  endtask
  task automatic test_reset();
    set_req(1, 1, 1, 2);
    set_rsp(1, 0, 32'h1234);
    #1 reset = 1'b1;
    #1;
    checks++; if ({dmd_gnt, pf_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {dmd_gnt, pf_gnt}); end
    checks++; if ({dmd_rsp.valid, pf_rsp.valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", {dmd_rsp.valid, pf_rsp.valid}); end
    checks++; if ({fb_req.valid, busy, err_sticky} !== 3'b000) begin failures++; $display("FAIL reset_state got=%b exp=000", {fb_req.valid, busy, err_sticky}); end
    tick();
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err_during got=%b exp=0", err_sticky); end
    do_reset();
  endtask
  task automatic test_starve();
    bit pend = 0;
    int pend_id = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      bit exp_pf;
      set_req(1, $urandom_range(15), 1, $urandom_range(15));
      set_rsp(pend, pend_id, $urandom);
      exp_pf = (c % 9) == 8;
      #3;
      checks++; if ({dmd_gnt, pf_gnt} !== {!exp_pf, exp_pf}) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", c, {dmd_gnt, pf_gnt}, {!exp_pf, exp_pf}); end
      tick();
      pend = fb_req.valid;
      pend_id = int'(fb_req.id);
    end
    do_reset();
  endtask
  task automatic test_full();
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(1, 10 + k, k == 4, 6);
      a = dmd_req.addr;
      #3;
      checks++; if ({dmd_gnt, pf_gnt} !== {k < 4, 1'b0}) begin failures++; $display("FAIL full_gnt k=%0d got=%b exp=%b", k, {dmd_gnt, pf_gnt}, {k < 4, 1'b0}); end
      tick();
      checks++; if (fb_req.valid !== (k < 4)) begin failures++; $display("FAIL full_fb_valid k=%0d got=%b", k, fb_req.valid); end
      if (k < 4) begin
        checks++; if (fb_req.id !== 4'(k) || fb_req.addr !== a) begin failures++; $display("FAIL full_fb_id k=%0d got=%0d/%h exp=%0d/%h", k, fb_req.id, fb_req.addr, k, a); end
      end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
    do_reset();
  endtask
  task automatic test_pf_route();
    logic [31:0] d;
    do_reset();
    set_req(1, 1, 0, 0); tick();
    set_req(1, 2, 0, 0); tick();
    set_req(0, 0, 1, 7); tick();
    set_req(1, 3, 0, 0); tick();
    d = $urandom;
    set_req(0, 0, 1, 5);
    set_rsp(1, 2, d);
    #3;
    checks++; if (pf_rsp.valid !== 1'b1 || pf_rsp.id !== 4'd7 || pf_rsp.data !== d) begin failures++; $display("FAIL route_pf got=%b/%0d/%h exp=1/7/%h", pf_rsp.valid, pf_rsp.id, pf_rsp.data, d); end
    checks++; if (dmd_rsp.valid !== 1'b0) begin failures++; $display("FAIL route_pf_dmd got=%b exp=0", dmd_rsp.valid); end
    checks++; if (pf_gnt !== 1'b0) begin failures++; $display("FAIL route_no_reuse got=%b exp=0", pf_gnt); end
    tick();
    d = $urandom;
    set_rsp(1, 0, d);
    #3;
    checks++; if (dmd_rsp.valid !== 1'b1 || dmd_rsp.id !== 4'd1 || dmd_rsp.data !== d || pf_rsp.valid !== 1'b0) begin failures++; $display("FAIL route_dmd got=%b/%0d/%h/%b exp=1/1/%h/0", dmd_rsp.valid, dmd_rsp.id, dmd_rsp.data, pf_rsp.valid, d); end
    checks++; if (pf_gnt !== 1'b1) begin failures++; $display("FAIL route_regrant got=%b exp=1", pf_gnt); end
    tick();
    set_rsp(0, 0, 0);
    checks++; if (fb_req.valid !== 1'b1 || fb_req.id !== 4'd2) begin failures++; $display("FAIL route_regrant_id got=%b/%0d exp=1/2", fb_req.valid, fb_req.id); end
    do_reset();
  endtask
  task automatic test_flush();
    do_reset();
    set_req(1, 4, 0, 0); tick();
    set_req(1, 5, 0, 0); tick();
    flush = 1'b1;
    set_req(1, 6, 1, 8);
    #3;
    checks++; if ({dmd_gnt, pf_gnt} !== 2'b00) begin failures++; $display("FAIL flush_gnt got=%b exp=00", {dmd_gnt, pf_gnt}); end
    checks++; if (fb_req.valid !== 1'b1 || fb_req.id !== 4'd1) begin failures++; $display("FAIL flush_prev_issue got=%b/%0d exp=1/1", fb_req.valid, fb_req.id); end
    tick();
    flush = 1'b0;
    set_req(0, 0, 0, 0);
    set_rsp(1, 0, $urandom);
    #3;
    checks++; if ({dmd_rsp.valid, pf_rsp.valid} !== 2'b00) begin failures++; $display("FAIL flush_drop0 got=%b exp=00", {dmd_rsp.valid, pf_rsp.valid}); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy1 got=%b exp=1", busy); end
    set_rsp(1, 1, $urandom);
    #3;
    checks++; if ({dmd_rsp.valid, pf_rsp.valid} !== 2'b00) begin failures++; $display("FAIL flush_drop1 got=%b exp=00", {dmd_rsp.valid, pf_rsp.valid}); end
    tick();
    set_rsp(0, 0, 0);
    checks++; if ({busy, err_sticky} !== 2'b00) begin failures++; $display("FAIL flush_idle got=%b exp=00", {busy, err_sticky}); end
    do_reset();
  endtask
  task automatic test_err();
    do_reset();
    set_rsp(1, 3, $urandom);
    #3;
    checks++; if ({dmd_rsp.valid, pf_rsp.valid} !== 2'b00) begin failures++; $display("FAIL err_drop got=%b exp=00", {dmd_rsp.valid, pf_rsp.valid}); end
    tick();
    set_rsp(0, 0, 0);
    tick(); tick(); tick();
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_sticky); end
    reset = 1'b1;
    #1;
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_sticky); end
    do_reset();
  endtask
  task automatic test_reset_outst();
    do_reset();
    for (int k = 0; k < 3; k++) begin set_req(1, k, 0, 0); tick(); end
    set_req(1, 9, 1, 9);
    set_rsp(1, 0, $urandom);
    reset = 1'b1;
    #1;
    checks++; if ({dmd_gnt, pf_gnt, dmd_rsp.valid, pf_rsp.valid, fb_req.valid, busy} !== 6'b0) begin failures++; $display("FAIL rst_outst got=%b exp=000000", {dmd_gnt, pf_gnt, dmd_rsp.valid, pf_rsp.valid, fb_req.valid, busy}); end
    tick();
    reset = 1'b0;
    set_req(1, 9, 0, 0);
    set_rsp(0, 0, 0);
    #3;
    checks++; if (dmd_gnt !== 1'b1) begin failures++; $display("FAIL rst_regrant got=%b exp=1", dmd_gnt); end
    tick();
    set_req(0, 0, 0, 0);
    set_rsp(1, 1, $urandom);
    checks++; if (fb_req.valid !== 1'b1 || fb_req.id !== 4'd0) begin failures++; $display("FAIL rst_first_id got=%b/%0d exp=1/0", fb_req.valid, fb_req.id); end
    tick();
    set_rsp(0, 0, 0);
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL rst_stale_rsp got=%b exp=1", err_sticky); end
    do_reset();
  endtask
  task automatic test_random();
    int q_id[$], q_due[$];
    int cyc = 0;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int lat = $urandom_range(1, 3);
      for (int k = 0; k < 110; k++) begin
        bit act = k < 100;
        set_req(act && ($urandom % 4 != 0), $urandom_range(15), act && ($urandom % 3 != 0), $urandom_range(15));
        flush = act && ($urandom % 20 == 0);
        if (q_due.size() > 0 && q_due[0] == cyc) begin
          set_rsp(1, q_id.pop_front(), $urandom);
          void'(q_due.pop_front());
        end else set_rsp($urandom % 40 == 0, N + $urandom_range(15 - N), $urandom);
        #3;
        model_eval();
        checks++; if ({dmd_gnt, pf_gnt} !== {e_dg, e_pg}) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {dmd_gnt, pf_gnt}, {e_dg, e_pg}); end
        checks++; if ({dmd_rsp.valid, pf_rsp.valid} !== {e_dv, e_pv}) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, {dmd_rsp.valid, pf_rsp.valid}, {e_dv, e_pv}); end
        if (e_dv) begin
          checks++; if (dmd_rsp.id !== e_rid || dmd_rsp.data !== ic_rsp.data) begin failures++; $display("FAIL rnd_dmd_rsp cyc=%0d got=%0d/%h exp=%0d/%h", cyc, dmd_rsp.id, dmd_rsp.data, e_rid, ic_rsp.data); end
        end
        if (e_pv) begin
          checks++; if (pf_rsp.id !== e_rid || pf_rsp.data !== ic_rsp.data) begin failures++; $display("FAIL rnd_pf_rsp cyc=%0d got=%0d/%h exp=%0d/%h", cyc, pf_rsp.id, pf_rsp.data, e_rid, ic_rsp.data); end
        end
        @(posedge clk);
        model_commit();
        #1;
        checks++; if (fb_req.valid !== m_fbv || (m_fbv && (fb_req.id !== 4'(m_fbid) || fb_req.addr !== m_fbaddr))) begin failures++; $display("FAIL rnd_fb cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, fb_req.valid, fb_req.id, fb_req.addr, m_fbv, m_fbid, m_fbaddr); end
        checks++; if (busy !== (pool[0].v | pool[1].v | pool[2].v | pool[3].v) || err_sticky !== m_err) begin failures++; $display("FAIL rnd_busy_err cyc=%0d got=%b/%b exp=%b/%b", cyc, busy, err_sticky, pool[0].v | pool[1].v | pool[2].v | pool[3].v, m_err); end
        if (fb_req.valid) begin q_id.push_back(int'(fb_req.id)); q_due.push_back(cyc + 1 + lat); end
        cyc++;
      end
    end
    do_reset();
  endtask
  initial begin
    set_req(0, 0, 0, 0);
    set_rsp(0, 0, 0);
    model_reset();
    test_reset();
    test_starve();
    test_full();
    test_pf_route();
    test_flush();
    test_err();
    test_reset_outst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
